quad_gate_tester: RTL and testbench

- Sequential self-checking tester for a quad 2-input gate chip: 7408 AND, 7432 OR, 7486 XOR or 7400 NAND.
- Drives the eight gate-input pins, waits for the outputs to settle, and samples the four gate-output pins.
- Compares the sampled outputs against the selected truth table and reports pass/fail per gate.
- Sits on the DE1-SoC board between the SW/KEY user inputs and the chip model or external chip; results go to LEDR.

---
 rtl/quad_gate_tester.sv | 148 ++++++++++++++
 tb/tb_quad_gate_tester.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gate_tester.sv
// Sequential tester for a quad 2-input gate chip (7408/7432/7486/7400).
// Walks four rotated input vectors, samples the chip after a settle delay and records per-gate mismatches.
module quad_gate_tester #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op_sel,
    output logic [7:0] dut_in,
    input  logic [3:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_gate,
    output logic [4:0] err_count,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [7:0] dut_in_q, dut_in_d;
    logic [3:0] fail_gate_q, fail_gate_d;
    logic [4:0] err_q, err_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [3:0] miss;

    function automatic logic gate_fn(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Gate k gets pair (vec+k) mod 4 so neighbouring gates never share a pair.
    function automatic logic [7:0] stim(input logic [1:0] vec);
        logic [7:0] d;
        logic [1:0] p;
        d = 8'h00;
        for (int k = 0; k < 4; k++) begin
            p = vec + 2'(k);
            d[2*k]   = p[1];
            d[2*k+1] = p[0];
        end
        return d;
    endfunction

    function automatic logic [3:0] expect_vec(input logic [1:0] vec, input logic [1:0] op);
        logic [3:0] e;
        logic [1:0] p;
        e = 4'h0;
        for (int k = 0; k < 4; k++) begin
            p = vec + 2'(k);
            e[k] = gate_fn(op, p[1], p[0]);
        end
        return e;
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        dut_in_d    = dut_in_q;
        fail_gate_d = fail_gate_q;
        err_d       = err_q;
        fail_vec_d  = fail_vec_q;
        miss        = dut_out ^ expect_vec(vec_q, op_q);
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = APPLY;
                    vec_d       = 2'd0;
                    cnt_d       = 8'd0;
                    op_d        = op_sel;
                    dut_in_d    = stim(2'd0);
                    fail_gate_d = 4'h0;
                    err_d       = 5'd0;
                    fail_vec_d  = 2'd0;
                end
            end
            APPLY: begin
                dut_in_d = stim(vec_q);
                if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                    state_d = CHECK;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CHECK: begin
                fail_gate_d = fail_gate_q | miss;
                err_d       = err_q + {2'b00, popcnt4(miss)};
                if (err_q == 5'd0 && miss != 4'h0) fail_vec_d = vec_q;
                if (vec_q == 2'd3) begin
                    state_d  = DONE;
                    dut_in_d = 8'h00;
                end else begin
                    state_d  = APPLY;
                    vec_d    = vec_q + 2'd1;
                    dut_in_d = stim(vec_q + 2'd1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= 2'd0;
            cnt_q       <= 8'd0;
            op_q        <= 2'd0;
            dut_in_q    <= 8'h00;
            fail_gate_q <= 4'h0;
            err_q       <= 5'd0;
            fail_vec_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            dut_in_q    <= dut_in_d;
            fail_gate_q <= fail_gate_d;
            err_q       <= err_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = (state_q == APPLY) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = done && (fail_gate_q == 4'h0);
    assign fail_gate = fail_gate_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Scoreboard bench for quad_gate_tester: a behavioural chip model drives dut_out and
// expected run results are queued at start and compared when done rises.
module tb_quad_gate_tester;

    typedef struct {
        logic       pass;
        logic [3:0] fg;
        logic [4:0] err;
        logic [1:0] fv;
        int         lat;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic [1:0] op0, op1;
    logic [7:0] din0, din1;
    logic [3:0] dout0, dout1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] fg0, fg1;
    logic [4:0] err0, err1;
    logic [1:0] fv0, fv1;

    logic [1:0] chip_op;
    logic [3:0] stuck0;
    logic       sel;

    logic       m_busy, m_done, m_pass;
    logic [7:0] m_din;
    logic [3:0] m_fg;
    logic [4:0] m_err;
    logic [1:0] m_fv;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    quad_gate_tester #(.SETTLE_CYCLES(4)) u_dut (
        .clock(clock), .reset(reset), .start(start0), .op_sel(op0),
        .dut_in(din0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_gate(fg0), .err_count(err0), .fail_vec(fv0)
    );

    quad_gate_tester #(.SETTLE_CYCLES(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .op_sel(op1),
        .dut_in(din1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_gate(fg1), .err_count(err1), .fail_vec(fv1)
    );

    function automatic logic fn(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Pin-level chip: gate k reads pins d[2k], d[2k+1]; stuck bits force the output low.
    function automatic logic [3:0] chip(input logic [7:0] d, input logic [1:0] cop, input logic [3:0] st);
        logic [3:0] o;
        o = 4'h0;
        for (int k = 0; k < 4; k++) o[k] = st[k] ? 1'b0 : fn(cop, d[2*k], d[2*k+1]);
        return o;
    endfunction

    always_comb begin
        dout0 = chip(din0, chip_op, stuck0);
        dout1 = chip(din1, chip_op, stuck0);
    end

    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_pass = sel ? pass1 : pass0;
    assign m_din  = sel ? din1  : din0;
    assign m_fg   = sel ? fg1   : fg0;
    assign m_err  = sel ? err1  : err0;
    assign m_fv   = sel ? fv1   : fv0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [1:0] cop,
                                   input logic [3:0] st, input int settle);
        exp_t e;
        logic [1:0] p;
        logic       a, b, got, want;
        e.fg = 4'h0; e.err = 5'd0; e.fv = 2'd0;
        e.lat = 4 * (settle + 1);
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) begin
                p    = 2'((v + k) % 4);
                a    = p[1];
                b    = p[0];
                got  = st[k] ? 1'b0 : fn(cop, a, b);
                want = fn(op, a, b);
                if (got != want) begin
                    if (e.err == 5'd0) e.fv = 2'(v);
                    e.fg[k] = 1'b1;
                    e.err   = e.err + 5'd1;
                end
            end
        end
        e.pass = (e.fg == 4'h0);
        return e;
    endfunction

    task automatic push_exp(input logic p, input logic [3:0] fg, input logic [4:0] err,
                            input logic [1:0] fv, input int lat);
        exp_t e;
        e.pass = p; e.fg = fg; e.err = err; e.fv = fv; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run(input logic s, input logic [1:0] op, input bit repulse);
        int   lat;
        logic busy_ok;
        exp_t e;
        sel = s;
        if (s) begin start1 = 1'b1; op1 = op; end
        else   begin start0 = 1'b1; op0 = op; end
        step();
        start0 = 1'b0; start1 = 1'b0;
        op0 = ~op; op1 = ~op;
        check("done_fall_e0", m_done, 0);
        check("din_vec0", m_din, 8'hD8);
        check("clear_e0", {m_pass, m_fg, m_err, m_fv}, 0);
        lat = 0;
        busy_ok = 1'b1;
        while (!m_done && lat < 200) begin
            if (!m_busy) busy_ok = 1'b0;
            if (repulse) begin
                if (s) start1 = (lat == 5); else start0 = (lat == 5);
            end
            step();
            lat++;
        end
        start0 = 1'b0; start1 = 1'b0;
        check("busy_run", busy_ok, 1);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("latency", lat, e.lat);
            check("pass", m_pass, e.pass);
            check("fail_gate", m_fg, e.fg);
            check("err_count", m_err, e.err);
            check("fail_vec", m_fv, e.fv);
        end
        check("busy_done", m_busy, 0);
        check("din_done", m_din, 8'h00);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; op0 = 2'b00; op1 = 2'b00;
        chip_op = 2'b00; stuck0 = 4'h0; sel = 1'b0;
        step(); step();
        check("rst_outs", {busy0, done0, pass0, fg0, err0, fv0, din0}, 0);
        reset = 1'b0;
        step();
        check("idle_outs", {busy0, done0, pass0, fg0, err0, fv0, din0}, 0);

        // Correct AND chip, AND expected.
        push_exp(1'b1, 4'h0, 5'd0, 2'd0, 20);
        run(1'b0, 2'b00, 1'b0);
        step(); step();
        check("done_held", done0, 1);

        // AND chip, OR expected.
        push_exp(1'b0, 4'hF, 5'd8, 2'd0, 20);
        run(1'b0, 2'b01, 1'b0);

        // Gate2 output stuck low.
        stuck0 = 4'b0100;
        push_exp(1'b0, 4'b0100, 5'd1, 2'd1, 20);
        run(1'b0, 2'b00, 1'b0);

        // Restart from a failing DONE with a good chip, start re-pulsed mid-run.
        stuck0 = 4'h0;
        push_exp(1'b1, 4'h0, 5'd0, 2'd0, 20);
        run(1'b0, 2'b00, 1'b1);

        // Asynchronous reset at vec 2.
        sel = 1'b0;
        start0 = 1'b1; op0 = 2'b01;
        step();
        start0 = 1'b0;
        repeat (10) step();
        check("vec2_din", din0, 8'h8D);
        check("vec2_err", err0, 5'd4);
        #2 reset = 1'b1;
        #1 check("async_rst", {busy0, done0, pass0, fg0, err0, fv0, din0}, 0);
        step();
        reset = 1'b0;
        repeat (5) step();
        check("post_rst_idle", {busy0, done0, pass0, fg0, err0, fv0, din0}, 0);
        push_exp(1'b1, 4'h0, 5'd0, 2'd0, 20);
        run(1'b0, 2'b00, 1'b0);

        // Randomised chips and expected functions.
        for (int i = 0; i < 4; i++) begin
            chip_op = 2'($urandom_range(0, 3));
            stuck0  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            op0     = 2'($urandom_range(0, 3));
            e = model(op0, chip_op, stuck0, 4);
            sb.push_back(e);
            run(1'b0, op0, 1'b0);
        end

        // Short settle build.
        chip_op = 2'b00; stuck0 = 4'h0;
        push_exp(1'b1, 4'h0, 5'd0, 2'd0, 8);
        run(1'b1, 2'b00, 1'b0);
        stuck0 = 4'b1000;
        e = model(2'b00, 2'b00, 4'b1000, 1);
        sb.push_back(e);
        run(1'b1, 2'b00, 1'b0);
        chip_op = 2'b10; stuck0 = 4'h0;
        e = model(2'b11, 2'b10, 4'h0, 1);
        sb.push_back(e);
        run(1'b1, 2'b11, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
